// File: rtl/cache_bus_arbiter_if.sv
// Requester, burst-engine and debug signals of cache_bus_arbiter bundled into one interface.
// slave = arbiter view; master = view of the caches and burst engine around it.
interface cache_bus_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = 1024
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_store;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*LINE_BITS-1:0]  req_wdata;
    logic [NREQ-1:0]            req_rready;
    logic [NREQ-1:0]            resp_valid;
    logic [LINE_BITS-1:0]       resp_data;
    logic                       mem_cmd_valid;
    logic                       mem_cmd_ready;
    logic                       mem_cmd_store;
    logic [ADDR_WIDTH-1:0]      mem_cmd_addr;
    logic [LINE_BITS-1:0]       mem_cmd_wdata;
    logic                       mem_resp_valid;
    logic [LINE_BITS-1:0]       mem_resp_data;
    logic [IDX_W-1:0]           grant_idx;

    modport slave (
        input  req_valid, req_store, req_addr, req_wdata, req_rready,
        input  mem_cmd_ready, mem_resp_valid, mem_resp_data,
        output resp_valid, resp_data,
        output mem_cmd_valid, mem_cmd_store, mem_cmd_addr, mem_cmd_wdata,
        output grant_idx
    );

    modport master (
        output req_valid, req_store, req_addr, req_wdata, req_rready,
        output mem_cmd_ready, mem_resp_valid, mem_resp_data,
        input  resp_valid, resp_data,
        input  mem_cmd_valid, mem_cmd_store, mem_cmd_addr, mem_cmd_wdata,
        input  grant_idx
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Single-outstanding line fill/write-back arbiter: 1 cycle req->mem_cmd_valid and mem_resp_valid->resp_valid.
// Holds the command until mem_cmd_ready and the response until req_rready; ARB_STARVE_GUARD_EN adds a starvation guard.
module cache_bus_arbiter #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    cache_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_grant_idx;
    logic                  r_cmd_vld;
    logic                  r_cmd_store;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LINE_BITS-1:0]  r_cmd_wdata;
    logic [NREQ-1:0]       r_resp_vld;
    logic [LINE_BITS-1:0]  r_resp_dat;

    logic                  w_any;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_store;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [LINE_BITS-1:0]  w_win_wdata;
    logic [NREQ-1:0]       w_grant_onehot;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_starve_cnt [NREQ];
`endif

    always_comb begin
        w_any       = |bus.req_valid;
        w_win_idx   = '0;
        w_win_store = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        // Scan downwards so the lowest requesting index is left standing.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) w_win_idx = IDX_W'(i);
        end
`ifdef ARB_STARVE_GUARD_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (r_starve_cnt[i] >= CNT_W'(STARVE_MAX))) w_win_idx = IDX_W'(i);
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_store = bus.req_store[i];
                w_win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_wdata = bus.req_wdata[i*LINE_BITS +: LINE_BITS];
            end
        end
        w_grant_onehot = NREQ'(1) << r_grant_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_cmd_vld   <= 1'b0;
            r_cmd_store <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_resp_vld  <= '0;
            r_resp_dat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_win_idx;
                        r_cmd_store <= w_win_store;
                        r_cmd_addr  <= w_win_addr;
                        r_cmd_wdata <= w_win_wdata;
                        r_cmd_vld   <= 1'b1;
                        r_state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        r_cmd_vld <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        r_resp_dat <= bus.mem_resp_data;
                        r_resp_vld <= w_grant_onehot;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.req_rready[r_grant_idx]) begin
                        r_resp_vld <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Counts IDLE arbitrations lost while requesting; saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) r_starve_cnt[i] <= '0;
        end else if (r_state == S_IDLE) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || (w_win_idx == IDX_W'(i)))
                    r_starve_cnt[i] <= '0;
                else if (r_starve_cnt[i] < CNT_W'(STARVE_MAX))
                    r_starve_cnt[i] <= r_starve_cnt[i] + 1'b1;
            end
        end
    end
`endif

    assign bus.mem_cmd_valid = r_cmd_vld;
    assign bus.mem_cmd_store = r_cmd_store;
    assign bus.mem_cmd_addr  = r_cmd_addr;
    assign bus.mem_cmd_wdata = r_cmd_wdata;
    assign bus.resp_valid    = r_resp_vld;
    assign bus.resp_data     = r_resp_dat;
    assign bus.grant_idx     = r_grant_idx;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: fill, conflict, write-back, backpressure, reset-in-WAIT, priority/guard.
module tb_cache_bus_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 64;
    localparam int LB   = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_bus_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .LINE_BITS(LB)) bus ();

    cache_bus_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .LINE_BITS(LB), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [LB-1:0] line_ab;
    logic [LB-1:0] line_55;
    logic [LB-1:0] exp_grant;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Drives a granted transaction (state CMD on entry) through to IDLE.
    task automatic run_txn();
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.req_rready     = '1;
        tick();
        bus.req_rready     = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        line_ab = {128{8'hAB}};
        line_55 = {128{8'h55}};
        bus.req_valid      = '0;
        bus.req_store      = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.req_rready     = '0;
        bus.mem_cmd_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk_eq("rst_resp_vld",  LB'(bus.resp_valid), '0);
        chk_eq("rst_cmd_vld",   LB'(bus.mem_cmd_valid), '0);
        chk_eq("rst_cmd_addr",  LB'(bus.mem_cmd_addr), '0);
        chk_eq("rst_grant",     LB'(bus.grant_idx), '0);
        chk_eq("rst_resp_data", bus.resp_data, '0);

        // Single fill from requester 1, which drops req_valid after the grant.
        bus.req_valid = 2'b10;
        bus.req_addr[1*AW +: AW] = 64'h1000;
        tick();
        chk_eq("fill_cmd_vld",   LB'(bus.mem_cmd_valid), 1);
        chk_eq("fill_cmd_addr",  LB'(bus.mem_cmd_addr), 'h1000);
        chk_eq("fill_cmd_store", LB'(bus.mem_cmd_store), 0);
        chk_eq("fill_grant",     LB'(bus.grant_idx), 1);
        bus.req_valid = 2'b00;
        tick();
        chk_eq("fill_cmd_hold", LB'(bus.mem_cmd_valid), 1);
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready = 1'b0;
        chk_eq("fill_wait_cmd_vld", LB'(bus.mem_cmd_valid), 0);
        chk_eq("fill_wait_resp",    LB'(bus.resp_valid), 0);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = line_ab;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk_eq("fill_resp_vld",  LB'(bus.resp_valid), 2'b10);
        chk_eq("fill_resp_data", bus.resp_data, line_ab);
        bus.req_rready = 2'b01;
        tick();
        chk_eq("fill_wrong_rready", LB'(bus.resp_valid), 2'b10);
        bus.req_rready = 2'b10;
        tick();
        bus.req_rready = 2'b00;
        chk_eq("fill_accept", LB'(bus.resp_valid), 0);

        // Conflict: requester 0 first, requester 1 in the IDLE after the accept.
        bus.req_valid = 2'b11;
        bus.req_addr[0*AW +: AW] = 64'h2000;
        bus.req_addr[1*AW +: AW] = 64'h3000;
        tick();
        chk_eq("conf_grant0", LB'(bus.grant_idx), 0);
        chk_eq("conf_addr0",  LB'(bus.mem_cmd_addr), 'h2000);
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk_eq("conf_resp0", LB'(bus.resp_valid), 2'b01);
        bus.req_rready = 2'b01;
        bus.req_valid  = 2'b10;
        tick();
        bus.req_rready = 2'b00;
        chk_eq("conf_idle_resp", LB'(bus.resp_valid), 0);
        chk_eq("conf_no_b2b",    LB'(bus.mem_cmd_valid), 0);
        tick();
        chk_eq("conf_grant1",   LB'(bus.grant_idx), 1);
        chk_eq("conf_addr1",    LB'(bus.mem_cmd_addr), 'h3000);
        chk_eq("conf_cmd_vld1", LB'(bus.mem_cmd_valid), 1);
        bus.req_valid = 2'b00;
        run_txn();

        // Write-back with command backpressure and a stray mem_resp_valid in CMD.
        bus.req_store = 2'b01;
        bus.req_addr[0*AW +: AW]  = 64'h4000;
        bus.req_wdata[0*LB +: LB] = line_55;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        chk_eq("wb_store", LB'(bus.mem_cmd_store), 1);
        chk_eq("wb_wdata", bus.mem_cmd_wdata, line_55);
        chk_eq("wb_grant", LB'(bus.grant_idx), 0);
        for (int k = 0; k < 10; k++) begin
            bus.mem_resp_valid = (k == 5);
            tick();
            chk_eq("bp_cmd_vld", LB'(bus.mem_cmd_valid), 1);
            chk_eq("bp_addr",    LB'(bus.mem_cmd_addr), 'h4000);
            chk_eq("bp_wdata",   bus.mem_cmd_wdata, line_55);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_cmd_ready  = 1'b1;
        tick();
        bus.mem_cmd_ready = 1'b0;
        chk_eq("wb_stray_resp", LB'(bus.resp_valid), 0);
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk_eq("wb_resp_vld", LB'(bus.resp_valid), 2'b01);
        bus.req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_eq("rbp_resp_vld", LB'(bus.resp_valid), 2'b01);
            chk_eq("rbp_no_cmd",   LB'(bus.mem_cmd_valid), 0);
        end
        bus.req_valid  = 2'b00;
        bus.req_rready = 2'b01;
        tick();
        bus.req_rready = 2'b00;
        bus.req_store  = 2'b00;
        chk_eq("wb_accept", LB'(bus.resp_valid), 0);

        // Reset while waiting for memory.
        bus.req_addr[0*AW +: AW] = 64'h5000;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid     = 2'b00;
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_eq("rw_cmd_vld",   LB'(bus.mem_cmd_valid), 0);
        chk_eq("rw_resp_vld",  LB'(bus.resp_valid), 0);
        chk_eq("rw_cmd_addr",  LB'(bus.mem_cmd_addr), 0);
        chk_eq("rw_cmd_wdata", bus.mem_cmd_wdata, '0);
        chk_eq("rw_resp_data", bus.resp_data, '0);
        chk_eq("rw_grant",     LB'(bus.grant_idx), 0);
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk_eq("rw_late_resp", LB'(bus.resp_valid), 0);
        tick();
        chk_eq("rw_late_resp2", LB'(bus.resp_valid), 0);
        chk_eq("rw_late_cmd",   LB'(bus.mem_cmd_valid), 0);

        // Both requesters held high across five arbitrations.
        bus.req_addr[0*AW +: AW] = 64'h6000;
        bus.req_addr[1*AW +: AW] = 64'h7000;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
`ifdef ARB_STARVE_GUARD_EN
            exp_grant = (k == 4) ? LB'(1) : LB'(0);
`else
            exp_grant = '0;
`endif
            chk_eq("prio_grant", LB'(bus.grant_idx), exp_grant);
            run_txn();
        end
        bus.req_valid = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
